// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with registered one-hot grant and hold.
// Define ARB_HOLD_LIMIT_EN to cap each tenure at MAX_HOLD cycles when others wait.
module rr_arbiter #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 4,
  localparam int ID_W     = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid
);

  logic [N-1:0]    r_gnt;
  logic [ID_W-1:0] r_gnt_id;
  logic [ID_W-1:0] r_last;
  logic            r_valid;

  logic            w_expired;
  logic            w_keep;
  logic            w_found;
  logic [ID_W-1:0] w_next;
  logic [ID_W-1:0] w_idx;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_TOP = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] r_hold;

  assign w_expired = (r_hold == HOLD_TOP) &&
                     ((req & ~r_gnt) != '0);

  // Saturates at the limit so a late competitor pre-empts at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
    end else if (w_keep) begin
      if (r_hold != HOLD_TOP) begin
        r_hold <= r_hold + 1'b1;
      end
    end else begin
      r_hold <= '0;
    end
  end
`else
  logic w_unused_hold;
  assign w_unused_hold = ^MAX_HOLD;
  assign w_expired     = 1'b0;
`endif

  assign w_keep = r_valid & req[r_gnt_id] & ~w_expired;

  // Search starts just past the last owner and wraps around.
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = ID_W'((int'(r_last) + k) % N);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_next  = w_idx;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_last   <= ID_W'(N - 1);
      r_valid  <= 1'b0;
    end else if (w_keep) begin
      r_gnt    <= r_gnt;
      r_gnt_id <= r_gnt_id;
      r_valid  <= 1'b1;
    end else if (w_found) begin
      r_gnt    <= N'(1) << w_next;
      r_gnt_id <= w_next;
      r_last   <= w_next;
      r_valid  <= 1'b1;
    end else begin
      r_gnt    <= '0;
      r_valid  <= 1'b0;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_valid;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: vector table, corner sequences and random traffic
// checked against a tenure-counting round-robin model.
module tb_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

`ifdef ARB_HOLD_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  int checks   = 0;
  int failures = 0;

  int m_owner;
  int m_ten;
  int m_last;
  int m_id;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       v;
  } vec_t;

  vec_t tbl[10];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic bit has(input logic [3:0] r, input int i);
    return (r & (4'b0001 << i)) != 4'b0000;
  endfunction

  function automatic void m_reset();
    m_owner = -1;
    m_ten   = 0;
    m_last  = N - 1;
    m_id    = 0;
  endfunction

  function automatic void m_step(input logic [3:0] r);
    int others;
    others = 0;
    for (int i = 0; i < N; i++)
      if (has(r, i) && i != m_owner) others++;
    if (m_owner >= 0 && has(r, m_owner) &&
        !(LIMIT && m_ten >= MH && others > 0)) begin
      m_ten++;
    end else if (r != 4'b0000) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (has(r, c)) begin
          m_owner = c;
          break;
        end
      end
      m_last = m_owner;
      m_id   = m_owner;
      m_ten  = 1;
    end else begin
      m_owner = -1;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string nm);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk({nm, " gnt"}, 32'(gnt), 32'(eg));
    chk({nm, " id"}, 32'(gnt_id), 32'(m_id));
    chk({nm, " valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    chk({nm, " inv"}, {30'b0, $onehot0(gnt), gnt_valid == (|gnt)},
        32'd3);
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clock);
    #1;
    m_step(r);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req   = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
    m_reset();
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] eg;

    tbl[0] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[1] = '{4'b1011, 4'b0010, 2'd1, 1'b1};
    tbl[2] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[3] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[4] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[5] = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[6] = '{4'b0101, 4'b0001, 2'd0, 1'b1};
    tbl[7] = '{4'b0110, 4'b0010, 2'd1, 1'b1};
    tbl[8] = '{4'b1100, 4'b0100, 2'd2, 1'b1};
    tbl[9] = '{4'b0000, 4'b0000, 2'd2, 1'b0};

    reset = 1'b0;
    req   = 4'b0000;
    m_reset();

    // async reset with no clock edge
    #1;
    reset = 1'b1;
    req   = 4'b1111;
    #1;
    chk("rst0 gnt", 32'(gnt), 32'h0);
    chk("rst0 valid", 32'(gnt_valid), 32'h0);
    chk("rst0 id", 32'(gnt_id), 32'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst1 gnt", 32'(gnt), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    m_reset();
    step(4'b1111);
    chk("rel gnt", 32'(gnt), 32'h1);
    chk("rel id", 32'(gnt_id), 32'h0);

    // vector table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].req);
      chk($sformatf("tbl%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d id", i), 32'(gnt_id), 32'(tbl[i].id));
      chk($sformatf("tbl%0d valid", i), 32'(gnt_valid), 32'(tbl[i].v));
    end

    // constant full request: rotation with limit, hold without
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(4'b1111);
      eg = LIMIT ? (4'b0001 << ((c / MH) % N)) : 4'b0001;
      chk($sformatf("full%0d gnt", c), 32'(gnt), 32'(eg));
      chk($sformatf("full%0d id", c), 32'(gnt_id),
          LIMIT ? 32'((c / MH) % N) : 32'h0);
    end
    step(4'b1110);
    chk("drop0 gnt", 32'(gnt), 32'h2);

    // sole requester never sees a gap
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(4'b0100);
      chk($sformatf("sole%0d gnt", c), 32'(gnt), 32'h4);
    end

    // reset mid-tenure drops grant immediately
    step(4'b0011);
    chk("pre gnt", 32'(gnt_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid gnt", 32'(gnt), 32'h0);
    chk("mid valid", 32'(gnt_valid), 32'h0);
    chk("mid id", 32'(gnt_id), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    m_reset();

    // random traffic against the model
    r = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0)
        r = 4'($urandom_range(0, 15));
      step(r);
      chk_model($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
